// File: rtl/upsample_pkg.sv
// Shared types and defaults for the 2x nearest-neighbour upsample sequencer.
package upsample_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_EMIT0 = 3'd2,
    ST_EMIT1 = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

  localparam int DATA_W_DEF = 8;
  localparam int IMG_W_DEF  = 64;
  localparam int IMG_H_DEF  = 48;
  localparam int UP_FACTOR  = 2;

endpackage

// File: rtl/upsample_line_buf.sv
// Single-row pixel store: one write port, one synchronous read port, storage not reset.
module upsample_line_buf #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64,
  parameter int AW     = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/upsample_ctrl.sv
// Frame sequencer for the 2x nearest-neighbour upsample: fills one row from a FWFT FIFO,
// then replays it twice with each pixel doubled. Optional sof/eol marks under UPSAMPLE_CTRL_MARK_EN.
module upsample_ctrl
  import upsample_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int COL_W  = 6,
  parameter int ROW_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic [DATA_W-1:0] din,
  input  logic              empty,
  output logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              valid_out,
  input  logic              ready_out,
  output logic [ROW_W:0]    out_row,
`ifdef UPSAMPLE_CTRL_MARK_EN
  output logic [COL_W:0]    out_col,
  output logic              sof,
  output logic              eol
`else
  output logic [COL_W:0]    out_col
`endif
);

  localparam int BEATS = UP_FACTOR * IMG_W;
  localparam logic [COL_W:0]   LAST_BEAT = (COL_W+1)'(BEATS - 1);
  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(IMG_H - 1);

  state_e            state;
  logic [COL_W-1:0]  in_col;
  logic [ROW_W-1:0]  in_row;
  logic [COL_W:0]    beat;
  logic              pass_done;
  logic              rd_ok;
  logic              emitting, fire, last_fire, can_load, adv_pix;
  logic [COL_W-1:0]  raddr;
  logic [DATA_W-1:0] rdata;

  assign emitting  = (state == ST_EMIT0) || (state == ST_EMIT1);
  assign rd_en     = (state == ST_FILL) & ~empty;
  assign fire      = valid_out & ready_out;
  assign last_fire = fire & (out_col == LAST_BEAT);
  assign can_load  = emitting & rd_ok & ~pass_done & (~valid_out | ready_out);

  // Read address runs one beat ahead so rdata already holds the pixel for the next load.
  assign adv_pix = can_load & beat[0] & (beat != LAST_BEAT);
  assign raddr   = beat[COL_W:1] + COL_W'(adv_pix);

  upsample_line_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (IMG_W),
    .AW     (COL_W)
  ) u_line_buf (
    .clk   (clk),
    .we    (rd_en),
    .waddr (in_col),
    .wdata (din),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      in_col    <= '0;
      in_row    <= '0;
      beat      <= '0;
      pass_done <= 1'b0;
      rd_ok     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      valid_out <= 1'b0;
      dout      <= '0;
      out_row   <= '0;
      out_col   <= '0;
`ifdef UPSAMPLE_CTRL_MARK_EN
      sof       <= 1'b0;
      eol       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;

      if (can_load) begin
        valid_out <= 1'b1;
        dout      <= rdata;
        out_col   <= beat;
        out_row   <= {in_row, state == ST_EMIT1};
`ifdef UPSAMPLE_CTRL_MARK_EN
        sof       <= (beat == '0) && (in_row == '0) && (state == ST_EMIT0);
        eol       <= (beat == LAST_BEAT);
`endif
        if (beat == LAST_BEAT) pass_done <= 1'b1;
        else                   beat      <= beat + 1'b1;
      end else if (fire) begin
        valid_out <= 1'b0;
`ifdef UPSAMPLE_CTRL_MARK_EN
        sof       <= 1'b0;
        eol       <= 1'b0;
`endif
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_FILL;
            busy   <= 1'b1;
            in_col <= '0;
            in_row <= '0;
          end
        end
        ST_FILL: begin
          beat      <= '0;
          pass_done <= 1'b0;
          rd_ok     <= 1'b0;
          if (rd_en) begin
            if (in_col == LAST_COL) begin
              in_col <= '0;
              state  <= ST_EMIT0;
            end else begin
              in_col <= in_col + 1'b1;
            end
          end
        end
        ST_EMIT0: begin
          rd_ok <= 1'b1;
          if (last_fire) begin
            state     <= ST_EMIT1;
            beat      <= '0;
            pass_done <= 1'b0;
            rd_ok     <= 1'b0;
          end
        end
        ST_EMIT1: begin
          rd_ok <= 1'b1;
          if (last_fire) begin
            beat      <= '0;
            pass_done <= 1'b0;
            rd_ok     <= 1'b0;
            if (in_row == LAST_ROW) begin
              state <= ST_FIN;
              done  <= 1'b1;
            end else begin
              in_row <= in_row + 1'b1;
              state  <= ST_FILL;
            end
          end
        end
        ST_FIN: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_upsample_ctrl.sv
// Bench for upsample_ctrl (IMG_W=4, IMG_H=2): scenario table, FIFO model, beat scoreboard.
module tb_upsample_ctrl;

  localparam int DW = 8, W = 4, H = 2, CW = 2, RW = 1;
  localparam int NPIX = W * H;
  localparam int NBEAT = 4 * W * H;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, rd_en, valid_out;
  logic          empty = 1'b1;
  logic          ready_out = 1'b0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout;
  logic [RW:0]   out_row;
  logic [CW:0]   out_col;
`ifdef UPSAMPLE_CTRL_MARK_EN
  logic          sof, eol;
`endif

  always #5 clk = ~clk;

  upsample_ctrl #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .COL_W(CW), .ROW_W(RW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .din(din), .empty(empty), .rd_en(rd_en),
    .dout(dout), .valid_out(valid_out), .ready_out(ready_out),
    .out_row(out_row),
`ifdef UPSAMPLE_CTRL_MARK_EN
    .out_col(out_col), .sof(sof), .eol(eol)
`else
    .out_col(out_col)
`endif
  );

  int n_vec = 0, n_err = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct packed {
    logic [DW-1:0] d;
    logic [RW:0]   r;
    logic [CW:0]   c;
    logic          sof;
    logic          eol;
  } beat_t;

  // FWFT FIFO model; empty can be forced high on alternate cycles.
  logic [DW-1:0] fifo_q[$];
  bit tog_mode = 0, tog_phase = 0;

  always begin
    @(posedge clk);
    if (rd_en && fifo_q.size() > 0) void'(fifo_q.pop_front());
    tog_phase = ~tog_phase;
    #1;
    empty = (fifo_q.size() == 0) || (tog_mode && tog_phase);
    din   = (fifo_q.size() > 0) ? fifo_q[0] : '0;
  end

  // Output monitor
  beat_t got_q[$];
  beat_t cur, held;
  bit    held_v = 0, done_prev = 0;
  int    cyc = 0, pops = 0, dones = 0, rd_empty = 0, done_cyc = 0;

  always @(negedge clk) begin
    cyc++;
    cur.d = dout; cur.r = out_row; cur.c = out_col;
`ifdef UPSAMPLE_CTRL_MARK_EN
    cur.sof = sof; cur.eol = eol;
`else
    cur.sof = 1'b0; cur.eol = 1'b0;
`endif
    if (rst) begin
      if (rd_en) begin
        pops++;
        if (empty) rd_empty++;
      end
      if (done) begin
        dones++;
        done_cyc = cyc;
        check("busy_at_done", busy, 1);
      end
      if (done_prev) check("busy_after_done", busy, 0);
      done_prev = done;
      if (held_v) begin
        check("stall_valid", valid_out, 1);
        check("stall_hold", cur, held);
      end
      held_v = valid_out && !ready_out;
      held   = cur;
      if (valid_out && ready_out) got_q.push_back(cur);
    end else begin
      held_v = 0;
      done_prev = 0;
    end
  end

  // Reference model: each input row -> two output rows, each pixel -> two beats.
  logic [DW-1:0] pix[NPIX];
  beat_t exp_q[$];

  function automatic void build_exp();
    beat_t b;
    exp_q.delete();
    for (int r = 0; r < 2 * H; r++)
      for (int c = 0; c < 2 * W; c++) begin
        b.d = pix[(r / 2) * W + c / 2];
        b.r = RW'(r) ; b.r = (RW+1)'(r);
        b.c = (CW+1)'(c);
`ifdef UPSAMPLE_CTRL_MARK_EN
        b.sof = (r == 0 && c == 0);
        b.eol = (c == 2 * W - 1);
`else
        b.sof = 1'b0;
        b.eol = 1'b0;
`endif
        exp_q.push_back(b);
      end
  endfunction

  typedef struct {
    bit tog;
    int rdy;       // 0 always ready, 1 random, 2 stall beat 3 for 3 cycles
    bit rnd;
    bit mid_start;
    int exp_beats;
    int exp_pops;
    int exp_dones;
  } scen_t;

  scen_t tbl[6];
  logic [DW-1:0] seq0[16];
  int base_lat = 0;

  task automatic run_frame(input scen_t s, input int idx, output int lat);
    int t0, stall_left;
    bit mid_done;
    fifo_q.delete();
    tog_mode = s.tog;
    for (int i = 0; i < NPIX; i++) begin
      pix[i] = s.rnd ? DW'($urandom) : DW'(8'h10 * (i + 1));
      fifo_q.push_back(pix[i]);
    end
    build_exp();
    ready_out = 1'b1;
    repeat (2) @(posedge clk);
    got_q.delete();
    pops = 0; dones = 0; rd_empty = 0;
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    t0 = cyc;
    check($sformatf("s%0d_busy_on_start", idx), busy, 1);
    stall_left = 3;
    mid_done = 0;
    for (int k = 0; k < 1000 && dones == 0; k++) begin
      @(posedge clk);
      #1;
      case (s.rdy)
        1: ready_out = 1'($urandom_range(0, 1));
        2: if (valid_out && out_row == 0 && out_col == 3 && stall_left > 0) begin
             if (stall_left == 3) check($sformatf("s%0d_stall_dout", idx), dout, 8'h20);
             ready_out = 1'b0;
             stall_left--;
           end else ready_out = 1'b1;
        default: ready_out = 1'b1;
      endcase
      if (s.mid_start && !mid_done && got_q.size() == 2) begin
        start = 1'b1;
        mid_done = 1;
      end else start = 1'b0;
    end
    start = 1'b0;
    ready_out = 1'b1;
    lat = done_cyc - t0;
    repeat (20) @(posedge clk);
    #1;
    check($sformatf("s%0d_beats", idx), got_q.size(), s.exp_beats);
    check($sformatf("s%0d_pops", idx), pops, s.exp_pops);
    check($sformatf("s%0d_dones", idx), dones, s.exp_dones);
    check($sformatf("s%0d_rd_while_empty", idx), rd_empty, 0);
    check($sformatf("s%0d_fifo_drained", idx), fifo_q.size(), 0);
    check($sformatf("s%0d_busy_end", idx), busy, 0);
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("s%0d_beat%0d", idx, i), got_q[i], exp_q[i]);
      if (!s.rnd) check($sformatf("s%0d_seq%0d", idx, i), got_q[i].d, seq0[(i / 16) * 8 + (i % 8)]);
    end
  endtask

  initial begin
    int lat;
    tbl[0] = '{tog:0, rdy:0, rnd:0, mid_start:0, exp_beats:NBEAT, exp_pops:NPIX, exp_dones:1};
    tbl[1] = '{tog:1, rdy:0, rnd:0, mid_start:0, exp_beats:NBEAT, exp_pops:NPIX, exp_dones:1};
    tbl[2] = '{tog:0, rdy:2, rnd:0, mid_start:0, exp_beats:NBEAT, exp_pops:NPIX, exp_dones:1};
    tbl[3] = '{tog:0, rdy:0, rnd:0, mid_start:1, exp_beats:NBEAT, exp_pops:NPIX, exp_dones:1};
    tbl[4] = '{tog:1, rdy:1, rnd:1, mid_start:0, exp_beats:NBEAT, exp_pops:NPIX, exp_dones:1};
    tbl[5] = '{tog:0, rdy:1, rnd:1, mid_start:0, exp_beats:NBEAT, exp_pops:NPIX, exp_dones:1};
    seq0 = '{8'h10, 8'h10, 8'h20, 8'h20, 8'h30, 8'h30, 8'h40, 8'h40,
             8'h50, 8'h50, 8'h60, 8'h60, 8'h70, 8'h70, 8'h80, 8'h80};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_valid", valid_out, 0);
    check("rst_dout", dout, 0);
    check("rst_out_row", out_row, 0);
    check("rst_out_col", out_col, 0);
    rst = 1'b1;

    for (int s = 0; s < 6; s++) begin
      run_frame(tbl[s], s, lat);
      if (s == 0) base_lat = lat;
      if (s == 3) check("s3_done_latency", lat, base_lat);
    end

    // Reset during EMIT1 of row 0, then a fresh frame
    fifo_q.delete();
    tog_mode = 0;
    for (int i = 0; i < NPIX; i++) fifo_q.push_back(DW'(8'hA0 + i));
    ready_out = 1'b1;
    repeat (2) @(posedge clk);
    got_q.delete();
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < 200 && got_q.size() < 11; k++) @(posedge clk);
    #1;
    check("rst_mid_reached", got_q.size() >= 11, 1);
    rst = 1'b0;
    #1;
    check("rst_mid_valid", valid_out, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_rd_en", rd_en, 0);
    check("rst_mid_out_row", out_row, 0);
    check("rst_mid_out_col", out_col, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    run_frame(tbl[0], 6, lat);
    check("s6_first_beat_pos", {got_q[0].r, got_q[0].c}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/upsample_ctrl.md
Name: upsample_ctrl

Overview:
- Frame sequencer for the 2x nearest-neighbour upsample stage of the SIFT octave pipeline.
- Pulls one input row of pixels from a first-word-fall-through (FWFT) FIFO into a line buffer.
- Emits that row twice, each pixel twice, producing a 2*IMG_W x 2*IMG_H stream for the first Gaussian/pyramid stage.
- Owns the row and column counters, FIFO read handshake, output valid/ready handshake and frame start/done control.

Parameters:
- DATA_W, 8: pixel width.
- IMG_W, 64: input pixels per row (>=2).
- IMG_H, 48: input rows per frame (>=1).
- COL_W, 6: input column counter width; must satisfy 2^COL_W >= IMG_W.
- ROW_W, 6: input row counter width; must satisfy 2^ROW_W >= IMG_H.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle frame start request.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse after the last output beat of the frame.
- din  input  DATA_W  FIFO head pixel; valid whenever empty=0.
- empty  input  1  FIFO empty flag.
- rd_en  output  1  FIFO pop; din is consumed in the same cycle.
- dout  output  DATA_W  upsampled pixel.
- valid_out  output  1  dout valid.
- ready_out  input  1  downstream accept.
- out_row  output  ROW_W+1  output row index of the current beat.
- out_col  output  COL_W+1  output column index of the current beat.

Behaviour:
- States: IDLE, FILL, EMIT0, EMIT1, FIN.
- Reset: while rst=0, state=IDLE and all counters=0; busy, done, rd_en, valid_out=0; dout, out_row, out_col=0.
- IDLE:
  - start=1 -> FILL; clear in_col and in_row; busy=1 the next cycle.
  - start is ignored in every other state.
- FILL:
  - rd_en = (state==FILL) & ~empty. It is combinational; there is no read while empty.
  - Each pop writes din to line_buf[in_col] and increments in_col.
  - The pop with in_col==IMG_W-1 -> EMIT0, with in_col cleared.
  - empty=1 stalls; counters hold.
- EMIT0 / EMIT1:
  - Each pass reads the line buffer (synchronous read, 1-cycle latency) and presents 2*IMG_W beats.
  - Beat k carries line_buf[k>>1].
  - First valid_out no later than 2 cycles after state entry.
  - Back-to-back beats at one per cycle while ready_out=1.
  - A beat completes when valid_out & ready_out.
  - While valid_out=1 and ready_out=0: dout, out_row and out_col are held stable; no beat is dropped or repeated.
- Transitions:
  - Last beat of EMIT0 -> EMIT1.
  - Last beat of EMIT1: if in_row==IMG_H-1 -> FIN; else increment in_row -> FILL.
- Indices: out_row = 2*in_row + (state==EMIT1); out_col = beat index 0..2*IMG_W-1.
- FIN: done=1 for exactly one cycle; busy=0 the next cycle -> IDLE.
- Frame totals: IMG_W*IMG_H FIFO pops; 4*IMG_W*IMG_H output beats.
- Overlap: FILL of the next row does not overlap EMIT1. One line buffer only; no ping-pong.
- Reset mid-frame: immediate return to reset values. A partially filled row is discarded. The FIFO is not flushed by this block.
- Simultaneous start and done in FIN: start is ignored; start must be re-issued in IDLE.

Optional Feature:
- Macro: UPSAMPLE_CTRL_MARK_EN.
- Defined: adds outputs sof (1 bit) and eol (1 bit), both qualified by valid_out and both reset to 0.
  - sof=1 on beat (out_row=0, out_col=0).
  - eol=1 on every beat with out_col=2*IMG_W-1.
  - Both are held during stalls like dout.
- Undefined: the ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package/include upsample_pkg holds:
  - state encodings (IDLE=0, FILL=1, EMIT0=2, EMIT1=3, FIN=4; 3-bit);
  - default DATA_W, IMG_W, IMG_H;
  - UP_FACTOR=2.
- Sub-module upsample_line_buf: IMG_W x DATA_W, one write port and one read port, synchronous read, no reset on storage. Instantiated once.

Test Plan (IMG_W=4, IMG_H=2, DATA_W=8):
- Start with the FIFO preloaded 0x10..0x80 (step 0x10), ready_out=1 -> 32 beats:
  - 10 10 20 20 30 30 40 40 on out_row 0 and 1;
  - 50 50 60 60 70 70 80 80 on out_row 2 and 3;
  - 8 rd_en pulses; one done pulse; busy drops after it.
- Same data with empty toggling every cycle during FILL -> identical output sequence; rd_en never asserted while empty=1.
- ready_out=0 for 3 cycles while beat 3 (0x20, out_col=3) is presented -> dout=0x20 and valid_out=1 held; the next accepted beat is 0x30 at out_col 4; total still 32.
- start pulsed during EMIT0 -> ignored; beat count and done timing unchanged; no second frame.
- rst driven low during EMIT1 of row 0 -> valid_out, busy, rd_en=0 at once. After release and a new start with fresh data, output restarts at out_row 0, out_col 0.
- UPSAMPLE_CTRL_MARK_EN defined, first scenario repeated -> sof only on beat 0; eol on beats 7, 15, 23, 31.
